// File: rtl/start_tick_gen_if.sv
// Button/timer handshake bundle between the start front-end and the countdown timer.
// slave is the start_tick_gen side; master is the timer/stimulus side.
interface start_tick_gen_if;
  logic btnRaw;
  logic doneCounting;
  logic start;
  logic tick1Hz;
  logic busy;

  modport slave (
    input  btnRaw,
    input  doneCounting,
    output start,
    output tick1Hz,
    output busy
  );

  modport master (
    output btnRaw,
    output doneCounting,
    input  start,
    input  tick1Hz,
    input  busy
  );
endinterface

// File: rtl/start_tick_gen.sv
// Conditions the start push-button into a single start pulse per countdown and
// generates the tick enable the countdown timer advances on.
module start_tick_gen #(
  parameter int CLK_HZ          = 100000000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic           Clk100M,
  input  logic           reset,
  start_tick_gen_if.slave io
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (DIV < 2) begin : g_bad_div
    $error("start_tick_gen: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("start_tick_gen: DEBOUNCE_CYCLES must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("start_tick_gen: SYNC_STAGES must be at least 2");
  end

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DEB_W-1:0]       r_deb_cnt;
  logic                   r_btn_stable;
  logic                   r_btn_stable_d;
  logic [DIV_W-1:0]       r_div;
  logic                   r_tick;
  logic                   r_start;
  logic                   r_busy;
  state_t                 r_state;

  logic w_btn_sync;
  logic w_press;
  logic w_launch;

  assign w_btn_sync = r_sync[SYNC_STAGES-1];
  assign w_press    = r_btn_stable & ~r_btn_stable_d;
  assign w_launch   = (r_state == ST_IDLE) && w_press;

  always_ff @(posedge Clk100M or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], io.btnRaw};
    end
  end

  // A level change is accepted only after it has persisted DEBOUNCE_CYCLES samples.
  always_ff @(posedge Clk100M or posedge reset) begin
    if (reset) begin
      r_deb_cnt      <= '0;
      r_btn_stable   <= 1'b0;
      r_btn_stable_d <= 1'b0;
    end else begin
      r_btn_stable_d <= r_btn_stable;
      if (w_btn_sync == r_btn_stable) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_btn_stable <= w_btn_sync;
        r_deb_cnt    <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
      end
    end
  end

  // doneCounting has priority in BUSY, so a press landing with it is dropped.
  always_ff @(posedge Clk100M or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_press) begin
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (io.doneCounting) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Restarting the divider with start gives the timer a full first second.
  always_ff @(posedge Clk100M or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_div == DIV_W'(DIV - 1));
      if (w_launch || (r_div == DIV_W'(DIV - 1))) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  assign io.start   = r_start;
  assign io.tick1Hz = r_tick;
  assign io.busy    = r_busy;

endmodule

// File: tb/tb_start_tick_gen.sv
// Randomised and directed bench for start_tick_gen against a cycle-level
// behavioural reference built from the button/timer rules.
module tb_start_tick_gen;
  localparam int CLK_HZ = 20;
  localparam int TICK_HZ = 1;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DEB = 4;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  start_tick_gen_if u_if ();

  start_tick_gen #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ),
    .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)
  ) u_dut (
    .Clk100M(clk),
    .reset(rst),
    .io(u_if)
  );

  int total = 0;
  int bad = 0;

  // reference model state
  logic q_raw[$];
  logic m_stable, m_prev, m_busy, m_start, m_tick;
  int   m_run, m_phase;

  // directed bookkeeping
  int e = 0;
  int n_start = 0;
  int start_edge = -1;
  int tick_edges[$];

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_raw.delete();
    for (int i = 0; i < SYNC; i++) q_raw.push_back(1'b0);
    m_stable = 0; m_prev = 0; m_busy = 0; m_start = 0; m_tick = 0;
    m_run = 0; m_phase = 0;
  endtask

  task automatic model_edge();
    logic seen, press;
    seen = q_raw.pop_front();
    q_raw.push_back(u_if.btnRaw);
    press = m_stable && !m_prev;
    m_prev = m_stable;
    if (seen != m_stable) begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = seen;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_start = !m_busy && press;
    if (m_busy) begin
      if (u_if.doneCounting) m_busy = 0;
    end else if (press) begin
      m_busy = 1;
    end
    m_tick = (m_phase == DIV - 1);
    m_phase = m_start ? 0 : (m_phase + 1) % DIV;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    e++;
    @(negedge clk);
    chk("start", int'(u_if.start), int'(m_start));
    chk("tick", int'(u_if.tick1Hz), int'(m_tick));
    chk("busy", int'(u_if.busy), int'(m_busy));
    if (u_if.start) begin
      n_start++;
      start_edge = e;
    end
    if (u_if.tick1Hz) tick_edges.push_back(e);
  endtask

  task automatic press_measure(input string tag);
    int s0;
    u_if.btnRaw = 1'b0;
    repeat (10) step();
    u_if.btnRaw = 1'b1;
    s0 = n_start;
    e = 0;
    start_edge = -1;
    repeat (12) step();
    chk({tag, "_cnt"}, n_start - s0, 1);
    chk({tag, "_edge"}, start_edge, SYNC + DEB + 1);
  endtask

  initial begin
    int s0, hold, bound;
    logic aligned;
    u_if.btnRaw = 1'b0;
    u_if.doneCounting = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_start", int'(u_if.start), 0);
    chk("rst_tick", int'(u_if.tick1Hz), 0);
    chk("rst_busy", int'(u_if.busy), 0);
    rst = 1'b0;

    // 1: held press from reset
    u_if.btnRaw = 1'b1;
    e = 0;
    tick_edges.delete();
    repeat (70) step();
    chk("t1_cnt", n_start, 1);
    chk("t1_edge", start_edge, 7);
    chk("t1_nticks", tick_edges.size(), 3);
    if (tick_edges.size() == 3) begin
      chk("t1_tick0", tick_edges[0], 27);
      chk("t1_tick1", tick_edges[1], 47);
      chk("t1_tick2", tick_edges[2], 67);
    end

    // 2: short blips never reach a start
    u_if.doneCounting = 1'b1;
    step();
    u_if.doneCounting = 1'b0;
    chk("t2_idle", int'(u_if.busy), 0);
    u_if.btnRaw = 1'b0;
    repeat (10) step();
    s0 = n_start;
    for (int r = 0; r < 5; r++) begin
      u_if.btnRaw = 1'b1;
      repeat (3) step();
      u_if.btnRaw = 1'b0;
      repeat (5) step();
    end
    chk("t2_nostart", n_start - s0, 0);
    chk("t2_busy", int'(u_if.busy), 0);

    // 3: bouncing contact then a solid hold
    for (int i = 0; i < 20; i++) begin
      u_if.btnRaw = ((i / 2) % 2) == 0;
      step();
    end
    u_if.btnRaw = 1'b1;
    s0 = n_start;
    e = 0;
    start_edge = -1;
    repeat (12) step();
    chk("t3_cnt", n_start - s0, 1);
    chk("t3_edge", start_edge, 7);

    // 4: presses while busy are dropped
    s0 = n_start;
    u_if.btnRaw = 1'b0;
    repeat (10) step();
    u_if.btnRaw = 1'b1;
    repeat (10) step();
    chk("t4_dropped", n_start - s0, 0);
    chk("t4_busy_hi", int'(u_if.busy), 1);
    u_if.doneCounting = 1'b1;
    step();
    u_if.doneCounting = 1'b0;
    chk("t4_busy_lo", int'(u_if.busy), 0);
    press_measure("t4");

    // 5: press coinciding with doneCounting loses
    u_if.btnRaw = 1'b0;
    repeat (10) step();
    u_if.btnRaw = 1'b1;
    s0 = n_start;
    aligned = 1'b0;
    for (int i = 0; i < 20 && !aligned; i++) begin
      u_if.doneCounting = m_stable && !m_prev;
      aligned = u_if.doneCounting;
      step();
    end
    u_if.doneCounting = 1'b0;
    repeat (3) step();
    chk("t5_align", int'(aligned), 1);
    chk("t5_busy", int'(u_if.busy), 0);
    chk("t5_nostart", n_start - s0, 0);
    press_measure("t5");

    // 6: async reset mid-countdown with divider at 13
    bound = 0;
    while (m_phase != 13 && bound < 40) begin
      step();
      bound++;
    end
    chk("t6_phase_reached", m_phase, 13);
    chk("t6_busy_pre", int'(u_if.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_start", int'(u_if.start), 0);
    chk("t6_rst_tick", int'(u_if.tick1Hz), 0);
    chk("t6_rst_busy", int'(u_if.busy), 0);
    model_reset();
    u_if.btnRaw = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    s0 = n_start;
    e = 0;
    tick_edges.delete();
    repeat (30) step();
    chk("t6_first_tick", (tick_edges.size() > 0) ? tick_edges[0] : -1, DIV);
    chk("t6_nostart", n_start - s0, 0);

    // random phase
    hold = 0;
    for (int c = 0; c < 2500; c++) begin
      if (hold == 0) begin
        u_if.btnRaw = $urandom_range(0, 1);
        hold = $urandom_range(1, 9);
      end
      hold--;
      u_if.doneCounting = m_busy ? ($urandom_range(0, 15) == 0)
                                 : ($urandom_range(0, 40) == 0);
      step();
    end
    u_if.doneCounting = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
